// File: rtl/am_inserter.sv
// AUI transmit AM insertion: packs two 257-bit block flows into 40-slot words.
// Build option AM_BYPASS_EN: no alignment markers, every word is 40 data blocks.
module am_inserter #(
  parameter int BITS_BLOCK     = 257,
  parameter int SLOTS_PER_WORD = 40,
  parameter int AM_PERIOD      = 4,
  parameter logic [BITS_BLOCK-1:0] AM_F0 = {1'b1, {32{8'hC1}}},
  parameter logic [BITS_BLOCK-1:0] AM_F1 = {1'b1, {32{8'h9E}}}
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 i_valid,
  input  logic [BITS_BLOCK-1:0]                flow_0,
  input  logic [BITS_BLOCK-1:0]                flow_1,
  output logic [BITS_BLOCK*SLOTS_PER_WORD-1:0] tx_scrambled_f0,
  output logic [BITS_BLOCK*SLOTS_PER_WORD-1:0] tx_scrambled_f1,
  output logic                                 valid_signal
);

  localparam int W  = BITS_BLOCK * SLOTS_PER_WORD;
  localparam int SW = $clog2(SLOTS_PER_WORD);
  localparam int PW = $clog2(AM_PERIOD);

  logic [W-1:0]  buf0_q, buf1_q;
  logic [W-1:0]  word0_d, word1_d;
  logic [W-1:0]  out0_q, out1_q;
  logic          valid_q;
  logic [SW-1:0] slot_q, slot_d;
  logic [PW-1:0] period_q, period_d;
  logic [SW-1:0] pos;
  logic          am_word;
  logic          last;

  // slot_q counts accepted blocks; an AM word shifts them up by one slot
  always_comb begin
`ifdef AM_BYPASS_EN
    am_word = 1'b0;
`else
    am_word = (period_q == '0);
`endif
    pos  = slot_q + SW'(am_word);
    last = (pos == SW'(SLOTS_PER_WORD - 1));
    word0_d = buf0_q;
    word1_d = buf1_q;
    for (int k = 0; k < SLOTS_PER_WORD; k++) begin
      if (SW'(k) == pos) begin
        word0_d[k*BITS_BLOCK +: BITS_BLOCK] = flow_0;
        word1_d[k*BITS_BLOCK +: BITS_BLOCK] = flow_1;
      end
    end
    if (am_word) begin
      word0_d[0 +: BITS_BLOCK] = AM_F0;
      word1_d[0 +: BITS_BLOCK] = AM_F1;
    end
    slot_d   = last ? '0 : slot_q + SW'(1);
    period_d = period_q;
`ifndef AM_BYPASS_EN
    if (last) begin
      if (period_q == PW'(AM_PERIOD - 1))
        period_d = '0;
      else
        period_d = period_q + PW'(1);
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf0_q   <= '0;
      buf1_q   <= '0;
      out0_q   <= '0;
      out1_q   <= '0;
      valid_q  <= 1'b0;
      slot_q   <= '0;
      period_q <= '0;
    end else begin
      valid_q <= 1'b0;
      if (i_valid) begin
        buf0_q   <= word0_d;
        buf1_q   <= word1_d;
        slot_q   <= slot_d;
        period_q <= period_d;
        if (last) begin
          out0_q  <= word0_d;
          out1_q  <= word1_d;
          valid_q <= 1'b1;
        end
      end
    end
  end

  assign tx_scrambled_f0 = out0_q;
  assign tx_scrambled_f1 = out1_q;
  assign valid_signal    = valid_q;

endmodule

// File: tb/tb_am_inserter.sv
// Directed bench for am_inserter with a word-level scoreboard.
// Build option AM_BYPASS_EN selects the no-marker expectations.
module tb_am_inserter;

  localparam int B = 257;
  localparam int S = 40;
  localparam int W = B * S;
  localparam logic [B-1:0] AMF0 = {1'b1, {32{8'hC1}}};
  localparam logic [B-1:0] AMF1 = {1'b1, {32{8'h9E}}};

  typedef logic [W-1:0] word_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_valid;
  logic [B-1:0] flow_0, flow_1;
  word_t        tx_scrambled_f0, tx_scrambled_f1;
  logic         valid_signal;

  am_inserter dut (
    .clk             (clk),
    .rst             (rst),
    .i_valid         (i_valid),
    .flow_0          (flow_0),
    .flow_1          (flow_1),
    .tx_scrambled_f0 (tx_scrambled_f0),
    .tx_scrambled_f1 (tx_scrambled_f1),
    .valid_signal    (valid_signal)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    fails  = 0;
  word_t q0[$], q1[$];
  word_t m0, m1;
  word_t last0, last1;
  int    mslot, mper;
  int    stepno;
  int    pulse_at[$];

  function automatic int first_diff(word_t a, word_t e);
    for (int k = 0; k < S; k++)
      if (a[k*B +: B] !== e[k*B +: B]) return k;
    return -1;
  endfunction

  task automatic cmp_word(input string tag, input word_t a, input word_t e);
    int k;
    checks++;
    k = first_diff(a, e);
    assert (a === e) else begin
      fails++;
      if (k < 0) k = 0;
      $error("FAIL %s slot=%0d got=%h exp=%h", tag, k,
             a[k*B +: B], e[k*B +: B]);
    end
  endtask

  task automatic cmp_slot(input string tag, input word_t a,
                          input int k, input logic [B-1:0] e);
    checks++;
    assert (a[k*B +: B] === e) else begin
      fails++;
      $error("FAIL %s slot=%0d got=%h exp=%h", tag, k, a[k*B +: B], e);
    end
  endtask

  task automatic cmp_bit(input string tag, input logic a, input logic e);
    checks++;
    assert (a === e) else begin
      fails++;
      $error("FAIL %s got=%b exp=%b", tag, a, e);
    end
  endtask

  task automatic cmp_int(input string tag, input int a, input int e);
    checks++;
    assert (a == e) else begin
      fails++;
      $error("FAIL %s got=%0d exp=%0d", tag, a, e);
    end
  endtask

  task automatic model_reset();
    mslot = 0;
    mper  = 0;
    m0    = '0;
    m1    = '0;
    last0 = '0;
    last1 = '0;
    q0.delete();
    q1.delete();
  endtask

  task automatic model_accept(input logic [B-1:0] b0, input logic [B-1:0] b1,
                              output logic done);
    done = 1'b0;
`ifndef AM_BYPASS_EN
    if (mslot == 0 && mper == 0) begin
      m0[0 +: B] = AMF0;
      m1[0 +: B] = AMF1;
      mslot = 1;
    end
`endif
    m0[mslot*B +: B] = b0;
    m1[mslot*B +: B] = b1;
    mslot++;
    if (mslot == S) begin
      q0.push_back(m0);
      q1.push_back(m1);
      mslot = 0;
      mper  = (mper + 1) % 4;
      done  = 1'b1;
    end
  endtask

  task automatic step(input logic v, input int n);
    logic  exp_pulse;
    word_t e0, e1;
    i_valid = v;
    flow_0  = B'(n);
    flow_1  = ~B'(n);
    exp_pulse = 1'b0;
    if (v) model_accept(B'(n), ~B'(n), exp_pulse);
    @(posedge clk);
    #1;
    stepno++;
    cmp_bit("pulse", valid_signal, exp_pulse);
    if (valid_signal === 1'b1) begin
      pulse_at.push_back(stepno);
      checks++;
      assert (q0.size() > 0) else begin
        fails++;
        $error("FAIL sb_empty got=%0d exp=1", q0.size());
      end
      if (q0.size() > 0) begin
        e0 = q0.pop_front();
        e1 = q1.pop_front();
        cmp_word("word_f0", tx_scrambled_f0, e0);
        cmp_word("word_f1", tx_scrambled_f1, e1);
        last0 = e0;
        last1 = e1;
      end
    end else begin
      cmp_word("hold_f0", tx_scrambled_f0, last0);
      cmp_word("hold_f1", tx_scrambled_f1, last1);
    end
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b0;
    i_valid = 1'b0;
    model_reset();
    #1;
    cmp_word("rst_f0", tx_scrambled_f0, '0);
    cmp_word("rst_f1", tx_scrambled_f1, '0);
    cmp_bit("rst_valid", valid_signal, 1'b0);
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    int n;
    int npc;
    rst = 1'b0;
    i_valid = 1'b0;
    flow_0 = '0;
    flow_1 = '0;
    stepno = 0;
    model_reset();

    // 1: reset held, then idle
    repeat (3) @(posedge clk);
    #1;
    cmp_word("rst3_f0", tx_scrambled_f0, '0);
    cmp_word("rst3_f1", tx_scrambled_f1, '0);
    cmp_bit("rst3_valid", valid_signal, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 0);

    // 2-4: continuous stream, five words
    pulse_at.delete();
    stepno = 0;
    npc = 0;
`ifdef AM_BYPASS_EN
    n = 200;
`else
    n = 198;
`endif
    for (int i = 0; i < n; i++) begin
      step(1'b1, i);
      if (valid_signal === 1'b1) begin
        npc++;
`ifdef AM_BYPASS_EN
        if (npc == 1) begin
          cmp_slot("w0_f0_s0", tx_scrambled_f0, 0, B'(0));
          cmp_slot("w0_f0_s39", tx_scrambled_f0, 39, B'(39));
        end
        if (npc == 2) cmp_slot("w1_f0_s0", tx_scrambled_f0, 0, B'(40));
`else
        if (npc == 1) begin
          cmp_slot("w0_f0_s0", tx_scrambled_f0, 0, AMF0);
          cmp_slot("w0_f0_s1", tx_scrambled_f0, 1, B'(0));
          cmp_slot("w0_f0_s39", tx_scrambled_f0, 39, B'(38));
          cmp_slot("w0_f1_s0", tx_scrambled_f1, 0, AMF1);
          cmp_slot("w0_f1_s1", tx_scrambled_f1, 1, ~B'(0));
        end
        if (npc == 2) begin
          cmp_slot("w1_f0_s0", tx_scrambled_f0, 0, B'(39));
          cmp_slot("w1_f0_s39", tx_scrambled_f0, 39, B'(78));
        end
        if (npc == 5) begin
          cmp_slot("w4_f0_s0", tx_scrambled_f0, 0, AMF0);
          cmp_slot("w4_f0_s1", tx_scrambled_f0, 1, B'(159));
        end
`endif
      end
    end
    cmp_int("pulse_count", pulse_at.size(), 5);
    if (pulse_at.size() == 5) begin
`ifdef AM_BYPASS_EN
      cmp_int("gap0", pulse_at[0], 40);
      for (int i = 1; i < 5; i++)
        cmp_int("gap", pulse_at[i] - pulse_at[i-1], 40);
`else
      cmp_int("gap0", pulse_at[0], 39);
      cmp_int("gap1", pulse_at[1] - pulse_at[0], 40);
      cmp_int("gap2", pulse_at[2] - pulse_at[1], 40);
      cmp_int("gap3", pulse_at[3] - pulse_at[2], 40);
      cmp_int("gap4", pulse_at[4] - pulse_at[3], 39);
`endif
    end

    // 5: toggled i_valid after a fresh reset
    @(posedge clk);
    do_reset(2);
    n = 0;
    while (mslot != 0 || n == 0) begin
      step(1'b1, n);
      n++;
      if (mslot != 0) step(1'b0, 0);
    end
    step(1'b0, 0);
`ifdef AM_BYPASS_EN
    cmp_slot("tog_f0_s39", tx_scrambled_f0, 39, B'(39));
`else
    cmp_slot("tog_f0_s0", tx_scrambled_f0, 0, AMF0);
    cmp_slot("tog_f0_s39", tx_scrambled_f0, 39, B'(38));
    cmp_slot("tog_f1_s1", tx_scrambled_f1, 1, ~B'(0));
`endif

    // 6: reset mid-word discards the partial word
    for (int i = 0; i < 20; i++) step(1'b1, 1000 + i);
    do_reset(1);
    n = 0;
    while (mslot != 0 || n == 0) begin
      step(1'b1, n);
      n++;
    end
`ifdef AM_BYPASS_EN
    cmp_int("mid_len", n, 40);
    cmp_slot("mid_f0_s0", tx_scrambled_f0, 0, B'(0));
`else
    cmp_int("mid_len", n, 39);
    cmp_slot("mid_f0_s0", tx_scrambled_f0, 0, AMF0);
    cmp_slot("mid_f0_s1", tx_scrambled_f0, 1, B'(0));
`endif
    for (int i = 0; i < 3; i++) step(1'b0, 0);
    cmp_int("sb_drained", q0.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
